// File: rtl/cache_mem_responder_pkg.sv
// Shared request-type codes, FSM state encoding and type decode helper
// for the cache memory responder.
package cache_mem_responder_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BUSY  = 2'd3
  } state_t;

  // Unlisted type codes fall back to word accesses, so only "line" is special.
  function automatic logic is_line(input logic [2:0] t);
    logic [2:0] norm;
    case (t)
      TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE: norm = t;
      default:                                    norm = TYPE_WORD;
    endcase
    return norm == TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_mem_responder_ram.sv
// Backing word array: LINE_WORDS interleaved banks so a whole line can be
// written in one cycle; single async read port, byte enables on word writes.
module cache_mem_responder_ram #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                    clk,
  input  logic [AW-1:0]           rd_idx,
  output logic [31:0]             rd_data,
  input  logic                    wr_en,
  input  logic                    wr_line,
  input  logic [AW-1:0]           wr_idx,
  input  logic [3:0]              wr_be,
  input  logic [32*LINE_WORDS-1:0] wr_data
);

  localparam int LB    = $clog2(LINE_WORDS);
  localparam int DEPTH = MEM_WORDS / LINE_WORDS;

  logic [31:0]      bank_rd [LINE_WORDS];
  logic [AW-LB-1:0] rd_row;
  logic [AW-LB-1:0] wr_row;
  logic [LB-1:0]    wr_bank;

  assign rd_row  = rd_idx[AW-1:LB];
  assign wr_row  = wr_idx[AW-1:LB];
  assign wr_bank = wr_idx[LB-1:0];

  for (genvar b = 0; b < LINE_WORDS; b++) begin : g_bank
    logic [31:0] mem [DEPTH];
    logic        bank_we;

    assign bank_we = wr_en && (wr_line || wr_bank == LB'(b));

    // Line writes fill every bank from its own slice; word writes merge bytes.
    always_ff @(posedge clk) begin
      if (bank_we) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_line) begin
            mem[wr_row][8*k +: 8] <= wr_data[32*b + 8*k +: 8];
          end else if (wr_be[k]) begin
            mem[wr_row][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
    end

    assign bank_rd[b] = mem[rd_row];
  end

  assign rd_data = bank_rd[rd_idx[LB-1:0]];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refills and writebacks: latency-modelled
// read bursts and single-shot writes into a local word array.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rd_req,
  input  logic [2:0]               rd_type,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic                     ret_last,
  output logic [31:0]              ret_data,
  input  logic                     wr_req,
  input  logic [2:0]               wr_type,
  input  logic [31:0]              wr_addr,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy
);

  localparam int AW      = $clog2(MEM_WORDS);
  localparam int LB      = $clog2(LINE_WORDS);
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LB-1:0] beat_q, beat_d;
  logic          line_q;
  logic [AW-1:0] idx_q;
  logic          ret_valid_q, ret_last_q;
  logic [31:0]   ret_data_q;

  logic          idle, rd_acc, wr_acc, cur_line, burst_d, last_d;
  logic [AW-1:0] cur_idx, ram_rd_idx;
  logic [31:0]   ram_rd_data;
  logic          unused_addr_bits;

  assign idle   = state_q == IDLE;
  assign wr_rdy = idle;
  // A colliding write wins; holding the read off keeps the refill from seeing stale data.
  assign rd_rdy = idle && !wr_req;
  assign wr_acc = wr_req && idle;
  assign rd_acc = rd_req && rd_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          state_d = WR_BUSY;
          cnt_d   = CW'(WR_LATENCY - 1);
        end else if (rd_acc) begin
          beat_d  = '0;
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = (RD_LATENCY == 1) ? RD_BURST : RD_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RD_BURST;
      end
      RD_BURST: begin
        if (ret_last_q) state_d = IDLE;
        else            beat_d  = beat_q + 1'b1;
      end
      WR_BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered one step ahead, so the array is read for the upcoming beat.
  assign cur_line   = idle ? is_line(rd_type) : line_q;
  assign cur_idx    = idle ? rd_addr[AW+1:2] : idx_q;
  assign ram_rd_idx = cur_line ? {cur_idx[AW-1:LB], beat_d} : cur_idx;
  assign burst_d    = state_d == RD_BURST;
  assign last_d     = !cur_line || (beat_d == LB'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      line_q      <= 1'b0;
      idx_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      if (rd_acc) begin
        line_q <= is_line(rd_type);
        idx_q  <= rd_addr[AW+1:2];
      end
      ret_valid_q <= burst_d;
      ret_last_q  <= burst_d && last_d;
      ret_data_q  <= burst_d ? ram_rd_data : '0;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;

  cache_mem_responder_ram #(
    .LINE_WORDS (LINE_WORDS),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clk     (clk),
    .rd_idx  (ram_rd_idx),
    .rd_data (ram_rd_data),
    .wr_en   (wr_acc && !reset),
    .wr_line (is_line(wr_type)),
    .wr_idx  (wr_addr[AW+1:2]),
    .wr_be   (wr_wstrb),
    .wr_data (wr_data)
  );

  // Byte offset and bits above the array alias away by design.
  assign unused_addr_bits = ^{rd_addr[31:AW+2], rd_addr[1:0], wr_addr[31:AW+2], wr_addr[1:0]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: default build (RD_LATENCY=2) plus
// a RD_LATENCY=1 build, with hand-computed expected beats.
module tb_cache_mem_responder;

  logic         clk;
  logic         reset;

  logic         rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [2:0]   rd_type, wr_type;
  logic [31:0]  rd_addr, wr_addr, ret_data;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;

  logic         b_rd_req, b_rd_rdy, b_ret_valid, b_ret_last, b_wr_req, b_wr_rdy;
  logic [2:0]   b_rd_type, b_wr_type;
  logic [31:0]  b_rd_addr, b_wr_addr, b_ret_data;
  logic [3:0]   b_wr_wstrb;
  logic [127:0] b_wr_data;

  int checks;
  int failures;

  cache_mem_responder #(
    .LINE_WORDS(4), .MEM_WORDS(1024), .RD_LATENCY(2), .WR_LATENCY(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  cache_mem_responder #(
    .LINE_WORDS(4), .MEM_WORDS(1024), .RD_LATENCY(1), .WR_LATENCY(1)
  ) u_dut_l1 (
    .clk(clk), .reset(reset),
    .rd_req(b_rd_req), .rd_type(b_rd_type), .rd_addr(b_rd_addr), .rd_rdy(b_rd_rdy),
    .ret_valid(b_ret_valid), .ret_last(b_ret_last), .ret_data(b_ret_data),
    .wr_req(b_wr_req), .wr_type(b_wr_type), .wr_addr(b_wr_addr), .wr_wstrb(b_wr_wstrb),
    .wr_data(b_wr_data), .wr_rdy(b_wr_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rq, input logic [2:0] rt, input logic [31:0] ra,
                               input logic wq, input logic [2:0] wt, input logic [31:0] wa,
                               input logic [3:0] ws, input logic [127:0] wd);
    rd_req   = rq;
    rd_type  = rt;
    rd_addr  = ra;
    wr_req   = wq;
    wr_type  = wt;
    wr_addr  = wa;
    wr_wstrb = ws;
    wr_data  = wd;
  endtask

  // Call right after driving a line read; checks the wait cycle, 4 beats and the return to idle.
  task automatic checkLineBurst(input string tag, input logic [127:0] words);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    checkOutput({tag, "_wait_valid"}, ret_valid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_beat%0d_valid", tag, b), ret_valid, 1'b1);
      checkOutput($sformatf("%s_beat%0d_data", tag, b), ret_data, words[32*b +: 32]);
      checkOutput($sformatf("%s_beat%0d_last", tag, b), ret_last, b == 3);
    end
    @(negedge clk);
    checkOutput({tag, "_end_valid"}, ret_valid, 1'b0);
    checkOutput({tag, "_end_data"}, ret_data, 32'h0);
    checkOutput({tag, "_end_rd_rdy"}, rd_rdy, 1'b1);
  endtask

  task automatic checkSingle(input string tag, input logic [31:0] word);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    checkOutput({tag, "_wait_valid"}, ret_valid, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, ret_valid, 1'b1);
    checkOutput({tag, "_data"}, ret_data, word);
    checkOutput({tag, "_last"}, ret_last, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_end_valid"}, ret_valid, 1'b0);
    checkOutput({tag, "_end_rd_rdy"}, rd_rdy, 1'b1);
  endtask

  task automatic writeAndSettle(input string tag, input logic [2:0] wt, input logic [31:0] wa,
                                input logic [3:0] ws, input logic [127:0] wd);
    applyStimulus(0, 3'b000, 0, 1, wt, wa, ws, wd);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    checkOutput({tag, "_busy_wr_rdy"}, wr_rdy, 1'b0);
    checkOutput({tag, "_busy_rd_rdy"}, rd_rdy, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_done_wr_rdy"}, wr_rdy, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    b_rd_req = 0; b_rd_type = 3'b000; b_rd_addr = 0;
    b_wr_req = 0; b_wr_type = 3'b000; b_wr_addr = 0; b_wr_wstrb = 0; b_wr_data = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle behaviour
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_rd_rdy", rd_rdy, 1'b1);
      checkOutput("idle_wr_rdy", wr_rdy, 1'b1);
      checkOutput("idle_ret_valid", ret_valid, 1'b0);
      checkOutput("idle_ret_last", ret_last, 1'b0);
      checkOutput("idle_ret_data", ret_data, 32'h0);
    end

    // Line write then unaligned line read: burst starts at the line base
    writeAndSettle("line_wr40", 3'b100, 32'h40, 4'h0, {32'h3, 32'h2, 32'h1, 32'h0});
    applyStimulus(1, 3'b100, 32'h48, 0, 3'b000, 0, 0, 0);
    checkLineBurst("line_rd48", {32'h3, 32'h2, 32'h1, 32'h0});

    // Byte-strobed word write merges into the old word 0x00000001
    writeAndSettle("word_wr44", 3'b010, 32'h44, 4'b0101, {96'h0, 32'hAABBCCDD});
    applyStimulus(1, 3'b000, 32'h45, 0, 3'b000, 0, 0, 0);
    checkSingle("byte_rd45", 32'h00BB00DD);

    // Zero strobes leave the word alone; unlisted read type acts as word
    writeAndSettle("nostrb_wr44", 3'b010, 32'h44, 4'b0000, {96'h0, 32'hFFFFFFFF});
    applyStimulus(1, 3'b111, 32'h44, 0, 3'b000, 0, 0, 0);
    checkSingle("oddtype_rd44", 32'h00BB00DD);

    // Simultaneous read and write: write first, read sees the new data
    applyStimulus(1, 3'b010, 32'h80, 1, 3'b010, 32'h80, 4'hF, {96'h0, 32'h12345678});
    #1;
    checkOutput("collide_rd_rdy", rd_rdy, 1'b0);
    checkOutput("collide_wr_rdy", wr_rdy, 1'b1);
    @(negedge clk);
    applyStimulus(1, 3'b010, 32'h80, 0, 3'b000, 0, 0, 0);
    checkOutput("collide_busy_wr_rdy", wr_rdy, 1'b0);
    checkOutput("collide_busy_rd_rdy", rd_rdy, 1'b0);
    checkOutput("collide_busy_valid", ret_valid, 1'b0);
    @(negedge clk);
    checkOutput("collide_idle_rd_rdy", rd_rdy, 1'b1);
    checkSingle("collide_rd80", 32'h12345678);

    // Reset during beat 2 aborts the burst
    applyStimulus(1, 3'b100, 32'h40, 0, 3'b000, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 3'b000, 0, 0, 3'b000, 0, 0, 0);
    checkOutput("abort_wait_valid", ret_valid, 1'b0);
    @(negedge clk);
    checkOutput("abort_beat0_data", ret_data, 32'h0);
    @(negedge clk);
    checkOutput("abort_beat1_data", ret_data, 32'h00BB00DD);
    @(negedge clk);
    checkOutput("abort_beat2_valid", ret_valid, 1'b1);
    checkOutput("abort_beat2_data", ret_data, 32'h2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_valid", ret_valid, 1'b0);
    checkOutput("abort_data", ret_data, 32'h0);
    checkOutput("abort_rd_rdy", rd_rdy, 1'b1);
    applyStimulus(1, 3'b100, 32'h40, 0, 3'b000, 0, 0, 0);
    checkLineBurst("post_reset_rd40", {32'h3, 32'h2, 32'h00BB00DD, 32'h0});

    // Address aliasing modulo the array depth
    applyStimulus(1, 3'b100, 32'h40 + 32'd4096, 0, 3'b000, 0, 0, 0);
    checkLineBurst("alias_rd1040", {32'h3, 32'h2, 32'h00BB00DD, 32'h0});

    // RD_LATENCY=1 build: first beat the cycle after accept
    b_wr_req = 1; b_wr_type = 3'b100; b_wr_addr = 32'h40;
    b_wr_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    @(negedge clk);
    b_wr_req = 0;
    checkOutput("l1_wr_busy", b_wr_rdy, 1'b0);
    @(negedge clk);
    checkOutput("l1_wr_done", b_wr_rdy, 1'b1);
    b_rd_req = 1; b_rd_type = 3'b100; b_rd_addr = 32'h4C;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      b_rd_req = 0;
      checkOutput($sformatf("l1_beat%0d_valid", b), b_ret_valid, 1'b1);
      checkOutput($sformatf("l1_beat%0d_data", b), b_ret_data, 32'hD0 + b);
      checkOutput($sformatf("l1_beat%0d_last", b), b_ret_last, b == 3);
    end
    @(negedge clk);
    checkOutput("l1_end_valid", b_ret_valid, 1'b0);
    checkOutput("l1_end_rd_rdy", b_rd_rdy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
